// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Word address width, matching fetch PC bits 25:2.
  localparam int IMEM_ADR_W = 24;

  // Number of length-header bytes preceding the payload.
  localparam int HDR_BYTES = 4;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer. Each push shifts a byte into the top
// of the word; the 4th push of a group completes the word. The completed
// word is presented combinationally alongside word_done so the caller can
// register it on the same edge that accepts the final byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  idx;
  logic [31:0] sh;

  // Incoming byte lands in bits 31:24; earlier bytes shift toward bit 0.
  assign word      = {byte_in, sh[31:8]};
  assign word_done = push && (idx == 2'd3);

  // Byte index and shift register; clear restarts word alignment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 2'd0;
      sh  <= 32'd0;
    end else if (clear) begin
      idx <= 2'd0;
      sh  <= 32'd0;
    end else if (push) begin
      idx <= idx + 2'd1;
      sh  <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length header, packs payload bytes
// into words written at consecutive word addresses, verifies an 8-bit
// additive checksum, and holds the core while the load is in progress.
//
// Stream handshake: a byte transfers on a rising edge where rx_valid and
// rx_ready are both high; rx_ready depends only on state, never on rx_valid,
// and the producer must hold rx_data stable while rx_valid is high and the
// byte has not yet transferred.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [IMEM_ADR_W-1:0] mem_adr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error,
  output loader_state_t         state_dbg
);

  loader_state_t         state, state_nxt;
  logic [31:0]           len;
  logic [IMEM_ADR_W-1:0] wcnt;
  logic [7:0]            csum;

  logic        accept;
  logic        start_ok;
  logic        pk_push;
  logic [31:0] pk_word;
  logic        pk_done;
  logic        hdr_bad;
  logic        hdr_zero;
  logic        last_word;

  assign accept   = rx_valid && rx_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                              (state == ST_ERR));
  assign pk_push  = accept && ((state == ST_LEN) || (state == ST_DATA));

  // Header decisions use the just-completed word, not the len register.
  assign hdr_bad   = pk_word > 32'(MAX_WORDS);
  assign hdr_zero  = (pk_word == 32'd0);
  assign last_word = ({{(32-IMEM_ADR_W){1'b0}}, wcnt} == (len - 32'd1));

  assign state_dbg = state;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .push      (pk_push),
    .byte_in   (rx_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    core_hold = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        rx_ready  = 1'b1;
        core_hold = 1'b1;
        if (pk_done) begin
          if (hdr_bad)       state_nxt = ST_ERR;
          else if (hdr_zero) state_nxt = ST_CSUM;
          else               state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready  = 1'b1;
        core_hold = 1'b1;
        if (pk_done && last_word) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        rx_ready  = 1'b1;
        core_hold = 1'b1;
        if (accept) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_LEN : ST_IDLE;
      end
      ST_ERR: begin
        error     = 1'b1;
        core_hold = 1'b1;
        if (start) state_nxt = ST_LEN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Length capture, word counter and payload checksum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len  <= 32'd0;
      wcnt <= '0;
      csum <= 8'd0;
    end else if (start_ok) begin
      len  <= 32'd0;
      wcnt <= '0;
      csum <= 8'd0;
    end else begin
      if ((state == ST_LEN) && pk_done) len <= pk_word;
      if ((state == ST_DATA) && accept) csum <= csum + rx_data;
      if ((state == ST_DATA) && pk_done) wcnt <= wcnt + 1'b1;
    end
  end

  // Registered one-cycle memory write per completed payload word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if ((state == ST_DATA) && pk_done) begin
        mem_we    <= 1'b1;
        mem_adr   <= wcnt;
        mem_wdata <= pk_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed steps plus randomized loads, with writes
// checked against a queue built from the word list of each load.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [IMEM_ADR_W-1:0] mem_adr;
  logic [31:0]           mem_wdata;
  logic                  core_hold;
  logic                  done;
  logic                  error;
  loader_state_t         state_dbg;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  logic [55:0] exp_q[$];     // {adr, data} of each expected write
  logic [7:0]  stream_q[$];  // bytes of the current load

  imem_loader #(.MAX_WORDS(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'd0, mem_adr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("write", {8'd0, mem_adr, mem_wdata}, {8'd0, exp_q.pop_front()});
      end
    end
    if (reset && done) done_cnt++;
  end

  // Reference model: builds the byte stream and expected writes from words.
  task automatic build_load(input logic [31:0] words[$], input bit bad);
    logic [7:0]  cs;
    logic [31:0] n;
    cs = 8'd0;
    n  = 32'(words.size());
    stream_q.delete();
    for (int i = 0; i < HDR_BYTES; i++) stream_q.push_back(8'((n >> (8 * i)) & 32'hFF));
    for (int w = 0; w < words.size(); w++) begin
      for (int b = 0; b < 4; b++) begin
        stream_q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
        cs = cs + 8'((words[w] >> (8 * b)) & 32'hFF);
      end
      exp_q.push_back({24'(w), words[w]});
    end
    stream_q.push_back(bad ? cs + 8'd1 : cs);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    bit ok;
    int guard;
    if (thr) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    ok       = 1'b0;
    do begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 50);
    if (!ok) chk("accept_timeout", 0, 1);
    rx_valid = 1'b0;
  endtask

  task automatic play(input int from, input int upto, input bit thr);
    for (int i = from; i < upto; i++) send_byte(stream_q[i], thr);
  endtask

  task automatic check_success(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold"}, core_hold, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    logic [31:0] wl[$];
    int base_wr;
    int base_done;
    int n;

    // Reset.
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {rx_ready, mem_we, core_hold, done, error}, 5'd0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed 2-word load.
    wl = '{32'h0000_0013, 32'h0010_0093};
    build_load(wl, 1'b0);
    chk("csum_byte_model", stream_q[12], 8'hB6);
    base_done = done_cnt;
    chk("idle_ready", rx_ready, 0);
    do_start();
    chk("start_ready", rx_ready, 1);
    chk("start_hold", core_hold, 1);
    play(0, 13, 1'b0);
    check_success("load2");
    chk("load2_done_cnt", done_cnt - base_done, 1);
    chk("load2_wr_cnt", wr_cnt, 2);

    // Bad checksum.
    build_load(wl, 1'b1);
    base_done = done_cnt;
    do_start();
    play(0, 13, 1'b0);
    chk("badcs_error", error, 1);
    chk("badcs_hold", core_hold, 1);
    chk("badcs_done", done, 0);
    chk("badcs_writes", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("badcs_sticky", error, 1);
    chk("badcs_no_done", done_cnt - base_done, 0);
    chk("badcs_ready", rx_ready, 0);
    do_start();
    chk("badcs_cleared", error, 0);
    chk("badcs_restart_hold", core_hold, 1);

    // Zero length, continuing from the start issued just above.
    wl.delete();
    build_load(wl, 1'b0);
    base_wr = wr_cnt;
    play(0, 4, 1'b0);
    chk("zero_in_csum_ready", rx_ready, 1);
    play(4, 5, 1'b0);
    check_success("zero");
    chk("zero_no_writes", wr_cnt - base_wr, 0);

    // Oversize header (4097).
    base_wr = wr_cnt;
    do_start();
    send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    chk("over_error", error, 1);
    chk("over_ready", rx_ready, 0);
    chk("over_hold", core_hold, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("over_no_writes", wr_cnt - base_wr, 0);

    // Maximum-length header (4096) is accepted into DATA.
    do_start();
    send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    chk("max_len_data", state_dbg, ST_DATA);
    chk("max_len_error", error, 0);
    reset = 1'b0; #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Throttled fixed 2-word load.
    wl = '{32'h0000_0013, 32'h0010_0093};
    build_load(wl, 1'b0);
    do_start();
    play(0, 13, 1'b1);
    check_success("thr2");

    // Randomized throttled loads.
    for (int k = 0; k < 4; k++) begin
      wl.delete();
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) wl.push_back($urandom);
      build_load(wl, 1'b0);
      do_start();
      play(0, stream_q.size(), 1'b1);
      check_success("rand");
    end

    // Mid-load reset after the 6th byte.
    wl = '{32'h0000_0013, 32'h0010_0093};
    build_load(wl, 1'b0);
    do_start();
    play(0, 6, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_outputs", {rx_ready, mem_we, core_hold, done, error}, 5'd0);
    chk("mrst_adr", mem_adr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    wl.delete();
    for (int i = 0; i < 3; i++) wl.push_back($urandom);
    build_load(wl, 1'b0);
    do_start();
    play(0, stream_q.size(), 1'b0);
    check_success("post_rst");

    // start pulsed during DATA is ignored.
    wl.delete();
    for (int i = 0; i < 2; i++) wl.push_back($urandom);
    build_load(wl, 1'b0);
    do_start();
    play(0, 7, 1'b0);
    do_start();
    chk("mid_start_state", state_dbg, ST_DATA);
    play(7, stream_q.size(), 1'b0);
    check_success("mid_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
